// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// Module   : md_sched
// Brief    : Multi-cycle multiply/divide unit with HI/LO registers and the
//            E-stage hazard stall that sequences it.
// Revision : 1.0 - initial release
// ============================================================================
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_RUN      = 1'b1;
    localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

    localparam logic [2:0] c_OP_MULT  = 3'd0;
    localparam logic [2:0] c_OP_MULTU = 3'd1;
    localparam logic [2:0] c_OP_DIV   = 3'd2;
    localparam logic [2:0] c_OP_DIVU  = 3'd3;
    localparam logic [2:0] c_OP_MTHI  = 3'd4;
    localparam logic [2:0] c_OP_MTLO  = 3'd5;

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_sh_hi;
    logic [31:0] r_sh_lo;
    logic        r_sh_wr;
    logic        r_issued;

    logic [0:0]  w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [31:0] w_sh_hi_nxt;
    logic [31:0] w_sh_lo_nxt;
    logic        w_sh_wr_nxt;
    logic        w_issued_nxt;

    logic        w_is_mul;
    logic        w_is_div;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [63:0] w_prod;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [31:0] w_rt_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    // ------------------------------------------------------------------
    // Datapath: the full result is computed in the issue cycle and parked
    // in the shadow registers until the configured latency has elapsed.
    // ------------------------------------------------------------------
    assign w_is_mul = (md_op == c_OP_MULT) || (md_op == c_OP_MULTU);
    assign w_is_div = (md_op == c_OP_DIV)  || (md_op == c_OP_DIVU);

    assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    assign w_prod   = md_op[0] ? w_prod_u : w_prod_s;

    // Signed divide via magnitudes so that 0x80000000 / -1 wraps cleanly.
    assign w_rs_neg  = ~md_op[0] & rs_val[31];
    assign w_rt_neg  = ~md_op[0] & rt_val[31];
    assign w_rs_mag  = w_rs_neg ? (~rs_val + 32'd1) : rs_val;
    assign w_rt_mag  = w_rt_neg ? (~rt_val + 32'd1) : rt_val;
    assign w_rt_safe = (rt_val == 32'd0) ? 32'd1 : w_rt_mag;
    assign w_q_mag   = w_rs_mag / w_rt_safe;
    assign w_r_mag   = w_rs_mag % w_rt_safe;
    assign w_quot    = (w_rs_neg ^ w_rt_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem     = w_rs_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // ------------------------------------------------------------------
    // Next-state / next-register logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_sh_hi_nxt  = r_sh_hi;
        w_sh_lo_nxt  = r_sh_lo;
        w_sh_wr_nxt  = r_sh_wr;
        w_issued_nxt = 1'b0;

        if (r_state == c_IDLE) begin
            if (start) begin
                if (w_is_mul) begin
                    w_sh_hi_nxt  = w_prod[63:32];
                    w_sh_lo_nxt  = w_prod[31:0];
                    w_sh_wr_nxt  = 1'b1;
                    w_cnt_nxt    = c_MULT_CNT;
                    w_state_nxt  = c_RUN;
                    w_issued_nxt = 1'b1;
                end else if (w_is_div) begin
                    w_sh_hi_nxt  = w_rem;
                    w_sh_lo_nxt  = w_quot;
                    // Divide by zero still takes the full latency but leaves HI/LO alone.
                    w_sh_wr_nxt  = (rt_val != 32'd0);
                    w_cnt_nxt    = c_DIV_CNT;
                    w_state_nxt  = c_RUN;
                    w_issued_nxt = 1'b1;
                end else if (md_op == c_OP_MTHI) begin
                    w_hi_nxt = rs_val;
                end else if (md_op == c_OP_MTLO) begin
                    w_lo_nxt = rs_val;
                end
            end
        end else begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
                w_state_nxt = c_IDLE;
                if (r_sh_wr) begin
                    w_hi_nxt = r_sh_hi;
                    w_lo_nxt = r_sh_lo;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= 4'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_sh_hi  <= 32'd0;
            r_sh_lo  <= 32'd0;
            r_sh_wr  <= 1'b0;
            r_issued <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_sh_hi  <= w_sh_hi_nxt;
            r_sh_lo  <= w_sh_lo_nxt;
            r_sh_wr  <= w_sh_wr_nxt;
            r_issued <= w_issued_nxt;
        end
    end

    assign busy     = (r_state == c_RUN);
    // r_issued only ever overlaps the first busy cycle; it keeps the stall
    // tied to the issuing op even if busy were ever decoded later.
    assign md_stall = md_use & (busy | r_issued);
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sched
// Brief    : Scoreboard bench for md_sched with a reference arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_sched;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .md_use   (md_use),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] ohi;
        logic [31:0] olo;
    } rec_t;

    rec_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mhi   = 32'd0;
    logic [31:0] mlo   = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: returns {hi,lo} after op, given current {h,l}.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint sa, sb_, q, r, p;
        logic [63:0] res;
        sa  = $signed(a);
        sb_ = $signed(b);
        res = {h, l};
        case (op)
            3'd0: begin p = sa * sb_; res = p; end
            3'd1: begin p = longint'({32'd0, a}) * longint'({32'd0, b}); res = p; end
            3'd2: if (b != 0) begin q = sa / sb_; r = sa % sb_; res = {r[31:0], q[31:0]}; end
            3'd3: if (b != 0) begin
                      q = longint'({32'd0, a}) / longint'({32'd0, b});
                      r = longint'({32'd0, a}) % longint'({32'd0, b});
                      res = {r[31:0], q[31:0]};
                  end
            3'd4: res = {a, l};
            3'd5: res = {h, a};
            default: res = {h, l};
        endcase
        return res;
    endfunction

    // Monitor: measures each busy burst and checks the completed result.
    int   run_len = 0;
    logic in_run  = 1'b0;
    logic held    = 1'b1;
    always @(negedge clk) begin
        rec_t r;
        if (reset) begin
            in_run  = 1'b0;
            run_len = 0;
        end else if (busy) begin
            if (!in_run) begin
                in_run  = 1'b1;
                run_len = 0;
                held    = 1'b1;
            end
            run_len++;
            if (sb.size() > 0 && (hi !== sb[0].ohi || lo !== sb[0].olo)) held = 1'b0;
        end else if (in_run) begin
            in_run = 1'b0;
            if (sb.size() == 0) begin
                chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
                r = sb.pop_front();
                chk("busy_len", run_len, r.n);
                chk("hilo_held_during_busy", {31'd0, held}, 32'd1);
                chk("result_hi", hi, r.hi);
                chk("result_lo", lo, r.lo);
            end
        end
    end

    // Issue one op from the negedge; return at a negedge once it has settled.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_, input int spur_at, input int rst_at);
        logic [63:0] e;
        rec_t        r;
        int          n, sc, k;
        e      = model(op, a, b, mhi, mlo);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        md_use = use_;
        n      = (op <= 3'd1) ? MC : DC;
        if (op <= 3'd3) begin
            r = '{n, e[63:32], e[31:0], mhi, mlo};
            sb.push_back(r);
        end
        @(posedge clk); #1;
        start = 1'b0;
        mhi   = e[63:32];
        mlo   = e[31:0];
        if (op > 3'd3) begin
            @(negedge clk);
            chk("nobusy_busy", {31'd0, busy}, 32'd0);
            chk("nobusy_hi", hi, mhi);
            chk("nobusy_lo", lo, mlo);
        end else begin
            sc = 0;
            for (k = 0; k < 40 && busy === 1'b1; k++) begin
                if (k == spur_at) begin
                    start  = 1'b1;
                    md_op  = 3'd5;
                    rs_val = 32'hDEAD;
                end
                if (k == rst_at) begin
                    reset = 1'b1;
                    sb.delete();
                    mhi = 32'd0;
                    mlo = 32'd0;
                end
                @(negedge clk);
                if (md_stall) sc++;
                @(posedge clk); #1;
                start = 1'b0;
                reset = 1'b0;
            end
            if (k >= 40) chk("busy_timeout", 32'd1, 32'd0);
            @(negedge clk);
            if (rst_at >= 0) begin
                chk("rst_mid_busy", {31'd0, busy}, 32'd0);
                chk("rst_mid_hi", hi, 32'd0);
                chk("rst_mid_lo", lo, 32'd0);
            end else begin
                chk("stall_cycles", sc, use_ ? n : 0);
                if (use_) chk("stall_after_busy", {31'd0, md_stall}, 32'd0);
            end
        end
        md_use = 1'b0;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        reset  = 1'b1;
        start  = 1'b1;
        md_op  = 3'd0;
        rs_val = 32'd5;
        rt_val = 32'd7;
        md_use = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        start  = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_stall", {31'd0, md_stall}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset  = 1'b0;
        md_use = 1'b0;

        do_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, -1, -1);
        do_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, -1, -1);
        do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, -1, -1);
        do_op(3'd3, 32'd7, 32'd2, 1'b0, -1, -1);
        do_op(3'd4, 32'h1234, 32'd0, 1'b0, -1, -1);
        do_op(3'd5, 32'h5678, 32'd0, 1'b0, -1, -1);
        do_op(3'd2, 32'd99, 32'd0, 1'b0, -1, -1);
        do_op(3'd3, 32'd99, 32'd0, 1'b1, -1, -1);
        do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1, -1);
        do_op(3'd0, 32'd3, 32'd4, 1'b1, -1, -1);
        do_op(3'd1, 32'd11, 32'd13, 1'b0, -1, -1);
        do_op(3'd2, 32'd100, 32'd3, 1'b0, -1, 2);
        do_op(3'd0, 32'd6, 32'd7, 1'b0, -1, -1);
        do_op(3'd0, 32'd9, 32'd9, 1'b1, 1, -1);
        do_op(3'd6, 32'hAAAA, 32'd1, 1'b0, -1, -1);
        do_op(3'd7, 32'hBBBB, 32'd1, 1'b0, -1, -1);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: b = 32'hFFFFFFFF;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            do_op(op, a, b, 1'($urandom_range(0, 1)), -1, -1);
        end

        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
